instr_fetch: RTL and testbench

Instruction fetch unit for the ARM core: the read-side initiator in front of the `rom` block. It holds the program counter and issues word reads to the ROM's synchronous port, then buffers the returned words in a small FIFO. It delivers instructions with their PC to decode over a valid/ready handshake. It also handles branch redirects and raises a fault when the PC leaves the ROM window (0x08000000–0x080FFFFF).

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM read port, decode handshake, redirect and fault signals of the fetch unit
interface instr_fetch_if;
  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        fetch_fault;
  logic [31:0] fault_address;
  modport master (
    output mem_address, mem_write_enable, mem_data_in, instr_valid, instr, instr_pc,
           fetch_fault, fault_address,
    input  mem_data_out, instr_ready, branch_valid, branch_target
  );
  modport slave (
    input  mem_address, mem_write_enable, mem_data_in, instr_valid, instr, instr_pc,
           fetch_fault, fault_address,
    output mem_data_out, instr_ready, branch_valid, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-gated ROM word reads and a small {instr, pc} FIFO toward decode
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0800_0000,
  parameter logic [31:0] ROM_BASE     = 32'h0800_0000,
  parameter logic [31:0] ROM_SIZE     = 32'h0010_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input logic           clock,
  input logic           reset_n,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic          resp_valid_q, resp_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_instr_d [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d [FIFO_DEPTH];
  logic          in_window, pop, push, issue;
  logic [CW:0]   credit;
  assign in_window = (pc_q - ROM_BASE) < ROM_SIZE;
  assign pop       = bus.instr_valid & bus.instr_ready;
  assign push      = resp_valid_q;
  assign credit    = {1'b0, count_q} + (CW+1)'(resp_valid_q) - (CW+1)'(pop);
  assign issue     = in_window & !bus.branch_valid & (credit < (CW+1)'(FIFO_DEPTH));
  assign bus.mem_address      = pc_q;
  assign bus.mem_write_enable = 1'b0;
  assign bus.mem_data_in      = 32'd0;
  assign bus.instr_valid      = count_q != '0;
  assign bus.instr            = fifo_instr_q[rd_ptr_q];
  assign bus.instr_pc         = fifo_pc_q[rd_ptr_q];
  assign bus.fetch_fault      = !in_window & (count_q == '0) & !resp_valid_q;
  assign bus.fault_address    = bus.fetch_fault ? pc_q : 32'd0;
  always_comb begin
    pc_d         = pc_q;
    resp_valid_d = 1'b0;
    resp_pc_d    = resp_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    if (bus.branch_valid) begin
      pc_d    = bus.branch_target & ~32'd3;
      count_d = '0;
    end else begin
      if (issue) begin
        resp_valid_d = 1'b1;
        resp_pc_d    = pc_q;
        pc_d         = pc_q + 32'd4;
      end
      if (push) begin
        fifo_instr_d[wr_ptr_q] = bus.mem_data_out;
        fifo_pc_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d               = wr_ptr_q + 1'b1;
      end
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
    end
    if (count_d == '0) begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = rd_ptr_q;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q         <= RESET_VECTOR;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a scoreboard of expected {pc, word} deliveries
module tb_instr_fetch;
  localparam logic [31:0] BASE = 32'h0800_0000;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rom_q;
  logic [63:0] exp_q[$];
  instr_fetch_if bus();
  instr_fetch dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return ((a - BASE) < 32'h0010_0000) ? 32'h1000_0000 + ((a - BASE) >> 2) : 32'hDEAD_BEEF;
  endfunction
  always @(posedge clock) rom_q <= rom_word(bus.mem_address);
  assign bus.mem_data_out = rom_q;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask
  task automatic push_seq(input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({addr + 32'(4 * i), rom_word(addr + 32'(4 * i))});
  endtask
  task automatic redirect(input logic [31:0] target);
    exp_q.delete();
    bus.branch_valid  = 1'b1;
    bus.branch_target = target;
  endtask
  always @(negedge clock) begin
    logic [63:0] e;
    chk("mem_write_enable", 32'(bus.mem_write_enable), 32'd0);
    chk("mem_data_in", bus.mem_data_in, 32'd0);
    if (reset_n && bus.instr_valid && bus.instr_ready && !bus.branch_valid) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL stream_extra: observed pc %h, expected no delivery", bus.instr_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stream_pc", bus.instr_pc, e[63:32]);
        chk("stream_instr", bus.instr, e[31:0]);
      end
    end
  end
  initial begin
    bus.instr_ready   = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'd0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_fault_addr", bus.fault_address, 32'd0);
    chk("rst_mem_addr", bus.mem_address, BASE);
    push_seq(BASE, 12);
    reset_n = 1'b1;
    bus.instr_ready = 1'b1;
    chk("lat_c0", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("lat_c1", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("lat_c2_valid", 32'(bus.instr_valid), 32'd1);
    chk("lat_c2_pc", bus.instr_pc, BASE);
    repeat (4) tick();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_pc", bus.instr_pc, BASE + 32'h10);
      chk("bp_instr", bus.instr, 32'h1000_0004);
      tick();
    end
    chk("bp_issue_stopped", bus.mem_address, BASE + 32'h18);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("resume_valid", 32'(bus.instr_valid), 32'd1);
      tick();
    end
    redirect(32'h0800_0403);
    push_seq(BASE + 32'h400, 8);
    tick();
    bus.branch_valid = 1'b0;
    chk("br_mem_addr", bus.mem_address, 32'h0800_0400);
    chk("br_n1_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("br_n2_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("br_n3_valid", 32'(bus.instr_valid), 32'd1);
    chk("br_n3_pc", bus.instr_pc, 32'h0800_0400);
    repeat (2) tick();
    redirect(32'h080F_FFF8);
    push_seq(32'h080F_FFF8, 2);
    tick();
    bus.branch_valid = 1'b0;
    chk("eow_mem_addr", bus.mem_address, 32'h080F_FFF8);
    repeat (2) tick();
    chk("eow_first_pc", bus.instr_pc, 32'h080F_FFF8);
    tick();
    chk("eow_last_pc", bus.instr_pc, 32'h080F_FFFC);
    chk("eow_no_fault_yet", 32'(bus.fetch_fault), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("eow_fault", 32'(bus.fetch_fault), 32'd1);
      chk("eow_fault_addr", bus.fault_address, 32'h0810_0000);
      chk("eow_valid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
    redirect(32'h0810_0000);
    tick();
    bus.branch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("oor_fault", 32'(bus.fetch_fault), 32'd1);
      chk("oor_fault_addr", bus.fault_address, 32'h0810_0000);
      chk("oor_valid", 32'(bus.instr_valid), 32'd0);
      tick();
    end
    redirect(32'h0800_0010);
    push_seq(BASE + 32'h10, 8);
    chk("rec_fault_held", 32'(bus.fetch_fault), 32'd1);
    tick();
    bus.branch_valid = 1'b0;
    chk("rec_fault_clear", 32'(bus.fetch_fault), 32'd0);
    chk("rec_fault_addr", bus.fault_address, 32'd0);
    chk("rec_mem_addr", bus.mem_address, 32'h0800_0010);
    repeat (2) tick();
    chk("rec_valid", 32'(bus.instr_valid), 32'd1);
    chk("rec_pc", bus.instr_pc, 32'h0800_0010);
    chk("rec_instr", bus.instr, 32'h1000_0004);
    redirect(32'h07FF_FFFC);
    tick();
    chk("below_fault", 32'(bus.fetch_fault), 32'd1);
    chk("below_fault_addr", bus.fault_address, 32'h07FF_FFFC);
    redirect(32'h0800_0020);
    push_seq(BASE + 32'h20, 8);
    bus.instr_ready = 1'b0;
    tick();
    bus.branch_valid = 1'b0;
    chk("below_rec_fault", 32'(bus.fetch_fault), 32'd0);
    repeat (4) tick();
    chk("full_valid", 32'(bus.instr_valid), 32'd1);
    chk("full_pc", bus.instr_pc, BASE + 32'h20);
    reset_n = 1'b0;
    redirect(32'h0800_0800);
    tick();
    reset_n = 1'b1;
    bus.branch_valid = 1'b0;
    push_seq(BASE, 8);
    bus.instr_ready = 1'b1;
    chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mrst_fault", 32'(bus.fetch_fault), 32'd0);
    chk("mrst_fault_addr", bus.fault_address, 32'd0);
    chk("mrst_mem_addr", bus.mem_address, BASE);
    tick();
    chk("mrst_c1_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("mrst_c2_valid", 32'(bus.instr_valid), 32'd1);
    chk("mrst_c2_pc", bus.instr_pc, BASE);
    repeat (3) tick();
    bus.instr_ready = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
